fifo_level_ctl: RTL and testbench

- Parametrised synchronous valid/ready FIFO, successor to the team's basic stream FIFO.
- Adds arbitrary (non-power-of-2) depth, an explicit occupancy count, programmable almost-full/almost-empty flags, and a synchronous flush.
- Sits between stream producers and consumers inside a single clock domain.
- Reads are fall-through by default.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ptr_wrap.sv | 27 ++
 rtl/fifo_level_ctl.sv | 150 +++++++++++++++
 tb/tb_fifo_level_ctl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared width helpers for fifo_level_ctl and its pointer sub-module.
package fifo_pkg;

  localparam int PTR_W_MIN = 1;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return ($clog2(depth) < PTR_W_MIN) ? PTR_W_MIN : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-Depth pointer: counts 0..Depth-1 and wraps explicitly, any Depth.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter  int Depth = 8,
  localparam int PtrW  = ptr_w(Depth)
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [PtrW-1:0] ptr_o
);

  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= (ptr_o == LastIdx) ? '0 : ptr_o + PtrW'(1);
    end
  end

endmodule

// File: rtl/fifo_level_ctl.sv
// Synchronous valid/ready FIFO with occupancy count, almost flags and flush.
// Define FIFO_OUT_REG_EN to register dout_o/dout_val_o (write-to-read latency 2).
module fifo_level_ctl
  import fifo_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int Depth     = 8,
  parameter int AfThr     = Depth - 2,
  parameter int AeThr     = 1
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [DataWidth-1:0]         din_i,
  input  logic                         din_val_i,
  output logic                         din_rdy_o,
  output logic [DataWidth-1:0]         dout_o,
  output logic                         dout_val_o,
  input  logic                         dout_rdy_i,
  input  logic                         flush_i,
  output logic [$clog2(Depth+1)-1:0]   level_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o
);

  localparam int LvlW = lvl_w(Depth);
  localparam int PtrW = ptr_w(Depth);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [LvlW-1:0]      level_q;
  logic                 full;
  logic                 empty;
  logic                 wr_hs;
  logic                 rd_hs;
  logic                 mem_pop;

  assign wr_hs = din_val_i & din_rdy_o;
  assign rd_hs = dout_val_o & dout_rdy_i;

  // Flags decode only from the level register, never from the inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    full           = 1'b0;
    empty          = 1'b0;
    almost_full_o  = 1'b0;
    almost_empty_o = 1'b0;
    full           = (level_q == LvlW'(Depth));
    empty          = (level_q == '0);
    almost_full_o  = (level_q >= LvlW'(AfThr));
    almost_empty_o = (level_q <= LvlW'(AeThr));
  end

  assign din_rdy_o = ~full;
  assign level_o   = level_q;

  // NOTE: storage has no reset; validity is tracked by level and pointers,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (wr_hs) begin
      mem[wr_ptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) begin
      level_q <= '0;
    end else if (wr_hs && !rd_hs) begin
      level_q <= level_q + LvlW'(1);
    end else if (rd_hs && !wr_hs) begin
      level_q <= level_q - LvlW'(1);
    end
  end

  fifo_ptr_wrap #(.Depth(Depth)) u_wr_ptr (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .clr_i  (flush_i),
    .inc_i  (wr_hs),
    .ptr_o  (wr_ptr)
  );

  fifo_ptr_wrap #(.Depth(Depth)) u_rd_ptr (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .clr_i  (flush_i),
    .inc_i  (mem_pop),
    .ptr_o  (rd_ptr)
  );

`ifdef FIFO_OUT_REG_EN
  logic                 out_val_q;
  logic [DataWidth-1:0] out_data_q;
  logic [LvlW-1:0]      mem_cnt;

  // level_q includes the output-register entry; the array holds the rest.
  assign mem_cnt = level_q - LvlW'(out_val_q);
  assign mem_pop = (mem_cnt != '0) && (!out_val_q || rd_hs);

  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) begin
      out_val_q <= 1'b0;
    end else if (mem_pop) begin
      out_val_q <= 1'b1;
    end else if (rd_hs) begin
      out_val_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_pop) begin
      out_data_q <= mem[rd_ptr];
    end
  end

  assign dout_val_o = out_val_q;
  assign dout_o     = out_data_q;
`else
  assign mem_pop    = rd_hs;
  assign dout_val_o = ~empty;
  assign dout_o     = mem[rd_ptr];
`endif

`ifndef SYNTHESIS
  logic                 blk_q;
  logic [DataWidth-1:0] din_q;

  always_ff @(posedge clk_i) begin
    blk_q <= din_val_i & ~din_rdy_o & ~srst_i;
    din_q <= din_i;
  end

  always @(posedge clk_i) begin
    if (!srst_i) begin
      assert (level_q <= LvlW'(Depth))
        else $error("fifo_level_ctl: level %0d exceeds depth", level_q);
      assert (!(wr_hs && full))
        else $error("fifo_level_ctl: write accepted while full");
      assert (!(rd_hs && empty))
        else $error("fifo_level_ctl: read accepted while empty");
      if (blk_q) begin
        assert (din_i == din_q)
          else $error("fifo_level_ctl: din_i changed while stalled");
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_level_ctl.sv
// Randomised and directed bench for fifo_level_ctl against a queue-based model.
`timescale 1ns/1ps
module tb_fifo_level_ctl;

  localparam int DW    = 16;
  localparam int DEPTH = 5;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef FIFO_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_val = 1'b0;
  logic          din_rdy;
  logic [DW-1:0] dout;
  logic          dout_val;
  logic          dout_rdy = 1'b0;
  logic          flush = 1'b0;
  logic [LW-1:0] level;
  logic          af;
  logic          ae;

  always #5 clk = ~clk;

  fifo_level_ctl #(.DataWidth(DW), .Depth(DEPTH), .AfThr(AF), .AeThr(AE)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .din_i          (din),
    .din_val_i      (din_val),
    .din_rdy_o      (din_rdy),
    .dout_o         (dout),
    .dout_val_o     (dout_val),
    .dout_rdy_i     (dout_rdy),
    .flush_i        (flush),
    .level_o        (level),
    .almost_full_o  (af),
    .almost_empty_o (ae)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: a queue of entries; the head becomes visible LAT cycles after it
  // entered, or immediately when the previous head left, whichever is later.
  typedef struct {
    logic [DW-1:0] d;
    int            w;
  } ent_t;

  ent_t q[$];
  int   head_vis  = 0;
  int   ncyc      = 0;
  bit   armed     = 0;
  bit   m_blocked = 0;

  function automatic bit m_valid();
    return (q.size() > 0) && (ncyc >= head_vis);
  endfunction

  initial begin
    bit   wr, rd;
    ent_t e;
    forever begin
      @(posedge clk);
      wr = din_val && (q.size() < DEPTH);
      rd = m_valid() && dout_rdy;
      m_blocked = din_val && (q.size() >= DEPTH);
      ncyc++;
      if (srst || flush) begin
        q.delete();
      end else begin
        if (rd) begin
          void'(q.pop_front());
          if (q.size() > 0) head_vis = (q[0].w + LAT > ncyc) ? q[0].w + LAT : ncyc;
        end
        if (wr) begin
          e.d = din;
          e.w = ncyc;
          if (q.size() == 0) head_vis = ncyc + LAT;
          q.push_back(e);
        end
      end
      armed = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("level", 32'(level), 32'(q.size()));
        check("din_rdy", 32'(din_rdy), 32'(q.size() < DEPTH));
        check("dout_val", 32'(dout_val), 32'(m_valid()));
        check("almost_full", 32'(af), 32'(q.size() >= AF));
        check("almost_empty", 32'(ae), 32'(q.size() <= AE));
        if (m_valid()) check("dout", 32'(dout), 32'(q[0].d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    din = v; din_val = 1'b1; cyc(); din_val = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    srst = 1'b0;
    check("rst_level", 32'(level), 0);
    check("rst_din_rdy", 32'(din_rdy), 1);
    check("rst_dout_val", 32'(dout_val), 0);
    check("rst_af", 32'(af), 0);
    check("rst_ae", 32'(ae), 1);

    // Fill to full, then drain in order
    for (int i = 1; i <= 5; i++) push(DW'(i));
    check("full_level", 32'(level), 5);
    check("full_din_rdy", 32'(din_rdy), 0);
    check("full_af", 32'(af), 1);
    check("full_ae", 32'(ae), 0);
    dout_rdy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("drain_val", 32'(dout_val), 1);
      check("drain_data", 32'(dout), 32'(i));
      cyc();
    end
    dout_rdy = 1'b0;
    check("drained_val", 32'(dout_val), 0);
    check("drained_level", 32'(level), 0);

    // Full boundary: read accepted, write refused, write lands next cycle
    for (int i = 0; i < 5; i++) push(DW'(16'h10 + i));
    din = 16'h15; din_val = 1'b1; dout_rdy = 1'b1;
    check("fb_din_rdy", 32'(din_rdy), 0);
    check("fb_head", 32'(dout), 32'h10);
    cyc();
    dout_rdy = 1'b0;
    check("fb_level_after_rd", 32'(level), 4);
    check("fb_din_rdy_after_rd", 32'(din_rdy), 1);
    cyc();
    din_val = 1'b0;
    check("fb_level_refill", 32'(level), 5);
    dout_rdy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("fb_data", 32'(dout), 32'(16'h10 + i));
      cyc();
    end
    dout_rdy = 1'b0;

    // Write into empty: visible after 1 (+LAT) cycles
    push(16'hBEEF);
    if (LAT != 0) begin
      check("beef_early_val", 32'(dout_val), 0);
      cyc();
    end
    check("beef_val", 32'(dout_val), 1);
    check("beef_data", 32'(dout), 32'hBEEF);
    dout_rdy = 1'b1; cyc(); dout_rdy = 1'b0;

    // Flush at level 3 with a concurrent write
    for (int i = 1; i <= 3; i++) push(DW'(16'h20 + i));
    check("pre_flush_level", 32'(level), 3);
    din = 16'h24; din_val = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; din_val = 1'b0;
    check("flush_level", 32'(level), 0);
    check("flush_val", 32'(dout_val), 0);
    check("flush_ae", 32'(ae), 1);
    push(16'h25);
    repeat (LAT) cyc();
    check("post_flush_data", 32'(dout), 32'h25);
    dout_rdy = 1'b1; cyc(); dout_rdy = 1'b0;

    // 12 writes interleaved with reads, level held at 2: pointers wrap
    push(16'h31); push(16'h32);
    repeat (LAT) cyc();
    for (int i = 2; i < 12; i++) begin
      din = DW'(16'h31 + i); din_val = 1'b1; dout_rdy = 1'b1;
      check("wrap_data", 32'(dout), 32'(16'h31 + i - 2));
      check("wrap_level", 32'(level), 2);
      cyc();
    end
    din_val = 1'b0;
    for (int i = 10; i < 12; i++) begin
      check("wrap_tail", 32'(dout), 32'(16'h31 + i));
      cyc();
    end
    dout_rdy = 1'b0;
    check("wrap_empty", 32'(level), 0);

    // Reset mid-burst at level 4
    for (int i = 1; i <= 4; i++) push(DW'(16'h40 + i));
    check("pre_rst_level", 32'(level), 4);
    din = 16'h45; din_val = 1'b1; srst = 1'b1;
    cyc();
    srst = 1'b0; din_val = 1'b0;
    check("mrst_level", 32'(level), 0);
    check("mrst_din_rdy", 32'(din_rdy), 1);
    check("mrst_val", 32'(dout_val), 0);
    check("mrst_af", 32'(af), 0);
    check("mrst_ae", 32'(ae), 1);
    push(16'h77);
    repeat (LAT) cyc();
    check("post_rst_data", 32'(dout), 32'h77);
    dout_rdy = 1'b1; cyc(); dout_rdy = 1'b0;

    // Random traffic with biased phases to reach both full and empty
    for (int n = 0; n < 3000; n++) begin
      int wp, rp;
      wp = ((n / 300) % 2 == 0) ? 80 : 30;
      rp = ((n / 300) % 2 == 0) ? 30 : 80;
      if (!m_blocked) begin
        din_val = ($urandom_range(0, 99) < wp);
        din     = DW'($urandom);
      end
      dout_rdy = ($urandom_range(0, 99) < rp);
      flush    = ($urandom_range(0, 199) == 0);
      srst     = ($urandom_range(0, 599) == 0);
      cyc();
    end
    din_val = 1'b0; dout_rdy = 1'b0; flush = 1'b0; srst = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
